// File: rtl/sprite_ram_arbiter_if.sv
// rtl/sprite_ram_arbiter_if.sv - host Avalon-MM slave bus into the sprite RAM arbiter
interface sprite_ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]   avs_address;
    logic                avs_read;
    logic                avs_write;
    logic [DATA_W-1:0]   avs_writedata;
    logic [DATA_W/8-1:0] avs_byteenable;
    logic                avs_waitrequest;
    logic [DATA_W-1:0]   avs_readdata;
    logic                avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_waitrequest, avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/sprite_ram_arbiter.sv
// rtl/sprite_ram_arbiter.sv - shares one single-port sprite RAM between row-burst display fetch and host access
module sprite_ram_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int ROW_W        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    sprite_ram_arbiter_if.slave avs,
    input  logic                disp_req,
    input  logic [ROW_W-1:0]    disp_row,
    output logic                disp_ack,
    output logic [DATA_W-1:0]   disp_pixel,
    output logic                disp_valid,
    output logic                disp_done,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_debugaccess,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);
    localparam int BEAT_W   = ADDR_W - ROW_W;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BURST   = 3'd1,
        DRAIN   = 3'd2,
        HOST_RD = 3'd3,
        HOST_RV = 3'd4
    } state_t;

    state_t              state;
    logic [ROW_W-1:0]    row;
    logic [BEAT_W-1:0]   beat;
    logic [STARVE_W-1:0] starve_cnt;
    logic                active;

    logic host_pending;
    logic idle;
    logic disp_grant;
    logic wr_grant;
    logic rd_grant;
    logic in_burst;

    // Grants are gated by 'active' so nothing reaches the RAM until the first clock after reset release.
    always_comb begin
        host_pending = avs.avs_read | avs.avs_write;
        idle         = (state == IDLE) && active;
        disp_grant   = idle && disp_req &&
                       (!host_pending || (starve_cnt < STARVE_W'(STARVE_LIMIT)));
        wr_grant     = idle && !disp_grant && avs.avs_write;
        rd_grant     = idle && !disp_grant && !avs.avs_write && avs.avs_read;
        in_burst     = (state == BURST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            row        <= '0;
            beat       <= '0;
            starve_cnt <= '0;
            active     <= 1'b0;
            disp_ack   <= 1'b0;
        end else begin
            active   <= 1'b1;
            disp_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (disp_grant) begin
                        state      <= BURST;
                        row        <= disp_row;
                        beat       <= '0;
                        disp_ack   <= 1'b1;
                        starve_cnt <= host_pending ? starve_cnt + 1'b1 : '0;
                    end else if (wr_grant || rd_grant) begin
                        starve_cnt <= '0;
                        if (rd_grant) state <= HOST_RV;
                    end
                end
                BURST: begin
                    beat <= beat + 1'b1;
                    if (beat == '1) state <= DRAIN;
                end
                DRAIN:   state <= IDLE;
                HOST_RV: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read data lags the address by one cycle, so pixels trail the burst address by one beat.
    always_comb begin
        mem_chipselect  = in_burst | wr_grant | rd_grant;
        mem_write       = wr_grant;
        mem_debugaccess = wr_grant;
        mem_clken       = active;
        if (in_burst)
            mem_address = {row, beat};
        else if (wr_grant || rd_grant)
            mem_address = avs.avs_address;
        else
            mem_address = '0;
        mem_writedata  = wr_grant ? avs.avs_writedata : '0;
        mem_byteenable = wr_grant ? avs.avs_byteenable : '1;

        avs.avs_waitrequest   = !(wr_grant || rd_grant);
        avs.avs_readdatavalid = (state == HOST_RV);
        avs.avs_readdata      = (state == HOST_RV) ? mem_readdata : '0;

        disp_valid = (in_burst && (beat != '0)) || (state == DRAIN);
        disp_done  = (state == DRAIN);
        disp_pixel = disp_valid ? mem_readdata : '0;
    end
endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// tb/tb_sprite_ram_arbiter.sv - randomized self-checking bench for sprite_ram_arbiter
module tb_sprite_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        disp_req;
    logic [3:0]  disp_row;
    logic        disp_ack;
    logic [15:0] disp_pixel;
    logic        disp_valid;
    logic        disp_done;
    logic [7:0]  mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic        mem_debugaccess;
    logic [15:0] mem_writedata;
    logic [1:0]  mem_byteenable;
    logic        mem_clken;
    logic [15:0] mem_readdata;
    logic        preload;

    sprite_ram_arbiter_if #(.ADDR_W(8), .DATA_W(16)) avs_bus ();

    sprite_ram_arbiter dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .avs             (avs_bus),
        .disp_req        (disp_req),
        .disp_row        (disp_row),
        .disp_ack        (disp_ack),
        .disp_pixel      (disp_pixel),
        .disp_valid      (disp_valid),
        .disp_done       (disp_done),
        .mem_address     (mem_address),
        .mem_chipselect  (mem_chipselect),
        .mem_write       (mem_write),
        .mem_debugaccess (mem_debugaccess),
        .mem_writedata   (mem_writedata),
        .mem_byteenable  (mem_byteenable),
        .mem_clken       (mem_clken),
        .mem_readdata    (mem_readdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Sprite RAM: registered read, byte-enabled write.
    logic [15:0] ram [256];
    always @(posedge clk) begin
        if (preload) begin
            for (int n = 0; n < 256; n++) ram[n] <= 16'hA000 + 16'(n);
        end else if (mem_chipselect) begin
            if (mem_write) begin
                if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
                if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    // Reference model: shadow memory plus queues of expected pixels and read data.
    logic [15:0] shadow [256];
    logic [15:0] pix_q [$];
    logic [15:0] rd_q [$];
    logic        burst_active = 1'b0;
    int          ack_total = 0;
    int          wr_cycles = 0;

    always @(negedge clk) begin
        if (preload)
            for (int n = 0; n < 256; n++) shadow[n] = 16'hA000 + 16'(n);
        if (!reset_n) begin
            pix_q.delete();
            rd_q.delete();
            burst_active = 1'b0;
        end else begin
            if (disp_ack) begin
                ack_total++;
                burst_active = 1'b1;
                for (int b = 0; b < 16; b++) pix_q.push_back(shadow[{disp_row, 4'(b)}]);
            end
            if (disp_valid) begin
                check("pix_expected", 32'(pix_q.size() != 0), 32'd1);
                if (pix_q.size() != 0) begin
                    check("pixel", 32'(disp_pixel), 32'(pix_q.pop_front()));
                    check("done_on_last", 32'(disp_done), 32'(pix_q.size() == 0));
                end
                if (disp_done) burst_active = 1'b0;
            end
            if (avs_bus.avs_readdatavalid) begin
                check("rdv_expected", 32'(rd_q.size() != 0), 32'd1);
                if (rd_q.size() != 0) check("readdata", 32'(avs_bus.avs_readdata), 32'(rd_q.pop_front()));
            end
            if (mem_write) begin
                wr_cycles++;
                check("write_granted", 32'(avs_bus.avs_write && !avs_bus.avs_waitrequest), 32'd1);
            end
            if (!avs_bus.avs_waitrequest) begin
                check("host_vs_burst", 32'(burst_active), 32'd0);
                check("mem_addr_host", 32'(mem_address), 32'(avs_bus.avs_address));
                if (avs_bus.avs_write) begin
                    check("mem_write_on_grant", 32'(mem_write & mem_debugaccess), 32'd1);
                    if (avs_bus.avs_byteenable[0]) shadow[avs_bus.avs_address][7:0]  = avs_bus.avs_writedata[7:0];
                    if (avs_bus.avs_byteenable[1]) shadow[avs_bus.avs_address][15:8] = avs_bus.avs_writedata[15:8];
                end else begin
                    check("read_be_ones", 32'(mem_byteenable), 32'h3);
                    rd_q.push_back(shadow[avs_bus.avs_address]);
                end
            end
        end
    end

    task automatic do_burst(input logic [3:0] row, output int lat, output int npix,
                            output logic [15:0] first, output logic [15:0] last);
        int got_ack = 0;
        lat = 0; npix = 0; first = '0; last = '0;
        @(posedge clk); #1;
        disp_req = 1'b1;
        disp_row = row;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (disp_ack) begin got_ack = 1; break; end
        end
        if (got_ack == 0) check("ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        disp_req = 1'b0;
        if (got_ack != 0) begin
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                lat++;
                if (disp_valid) begin
                    if (npix == 0) first = disp_pixel;
                    last = disp_pixel;
                    npix++;
                end
                if (disp_done) break;
            end
        end
    endtask

    task automatic host_op(input logic wr, input logic rd, input logic [7:0] addr,
                           input logic [15:0] data, input logic [1:0] be, output int waits);
        int accepted = 0;
        waits = 0;
        @(posedge clk); #1;
        avs_bus.avs_write = wr;
        avs_bus.avs_read = rd;
        avs_bus.avs_address = addr;
        avs_bus.avs_writedata = data;
        avs_bus.avs_byteenable = be;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!avs_bus.avs_waitrequest) begin accepted = 1; break; end
            waits++;
        end
        if (accepted == 0) check("host_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        avs_bus.avs_write = 1'b0;
        avs_bus.avs_read = 1'b0;
    endtask

    int          lat, npix, waits, acks, acks_before, ack0, wr0, rd_now;
    logic [15:0] first, last;
    logic [3:0]  row;
    logic [7:0]  addr;
    int          done_seen;

    initial begin
        reset_n = 1'b0; preload = 1'b1;
        disp_req = 1'b0; disp_row = '0;
        avs_bus.avs_address = '0; avs_bus.avs_read = 1'b0; avs_bus.avs_write = 1'b0;
        avs_bus.avs_writedata = '0; avs_bus.avs_byteenable = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_waitrequest", 32'(avs_bus.avs_waitrequest), 32'd1);
        check("rst_byteenable", 32'(mem_byteenable), 32'h3);
        check("rst_outputs_zero", 32'({disp_ack, disp_valid, disp_done, mem_chipselect, mem_write,
                                       mem_clken, avs_bus.avs_readdatavalid}), 32'd0);
        @(posedge clk); #1;
        preload = 1'b0; reset_n = 1'b1;
        repeat (2) @(posedge clk);
        check("clken_after_reset", 32'(mem_clken), 32'd1);

        // Row 3 burst
        ack0 = ack_total;
        do_burst(4'd3, lat, npix, first, last);
        check("b3_lat", 32'(lat), 32'd16);
        check("b3_npix", 32'(npix), 32'd16);
        check("b3_first", 32'(first), 32'hA030);
        check("b3_last", 32'(last), 32'hA03F);
        repeat (2) @(posedge clk);
        check("b3_one_ack", 32'(ack_total - ack0), 32'd1);

        // Byte-enabled write then read back
        host_op(1'b1, 1'b0, 8'h25, 16'h1234, 2'b01, waits);
        check("wr_waits", 32'(waits), 32'd0);
        host_op(1'b0, 1'b1, 8'h25, 16'h0, 2'b11, waits);
        check("rd_waits", 32'(waits), 32'd0);
        @(negedge clk);
        check("rd_valid", 32'(avs_bus.avs_readdatavalid), 32'd1);
        check("rd_data", 32'(avs_bus.avs_readdata), 32'hA034);

        // Simultaneous read and write: write wins, no read data
        wr0 = wr_cycles;
        host_op(1'b1, 1'b1, 8'h10, 16'hBEEF, 2'b11, waits);
        check("rw_waits", 32'(waits), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rw_no_rdv", 32'(avs_bus.avs_readdatavalid), 32'd0);
        end
        check("rw_one_write", 32'(wr_cycles - wr0), 32'd1);

        // Display wins a same-cycle tie; host waits the full burst period
        fork
            do_burst(4'd5, lat, npix, first, last);
            host_op(1'b0, 1'b1, 8'h52, 16'h0, 2'b11, waits);
        join
        check("tie_waits", 32'(waits), 32'd18);
        check("tie_npix", 32'(npix), 32'd16);

        // Continuous display fetch with a pending host read
        for (int round = 0; round < 2; round++) begin
            @(posedge clk); #1;
            disp_req = 1'b1; disp_row = 4'(7 + round);
            avs_bus.avs_read = 1'b1; avs_bus.avs_address = 8'h33;
            acks = 0; acks_before = -1;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (disp_ack) acks++;
                rd_now = (avs_bus.avs_read && !avs_bus.avs_waitrequest) ? 1 : 0;
                if (rd_now != 0) acks_before = acks;
                if (acks_before >= 0 && acks > acks_before) break;
                @(posedge clk); #1;
                if (rd_now != 0) avs_bus.avs_read = 1'b0;
            end
            @(posedge clk); #1;
            disp_req = 1'b0;
            avs_bus.avs_read = 1'b0;
            done_seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (disp_done) begin done_seen = 1; break; end
            end
            check("starve_bursts", 32'(acks_before), 32'd4);
            check("starve_resume", 32'(acks > acks_before), 32'd1);
            check("starve_done", 32'(done_seen), 32'd1);
        end

        // Reset at beat 7 aborts the burst
        @(posedge clk); #1;
        disp_req = 1'b1; disp_row = 4'd9;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (disp_ack) break;
        end
        @(posedge clk); #1;
        disp_req = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("abort_outputs", 32'({disp_valid, disp_done, mem_chipselect, mem_write, disp_pixel}), 32'd0);
        check("abort_waitrequest", 32'(avs_bus.avs_waitrequest), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'({disp_valid, disp_done}), 32'd0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        do_burst(4'd0, lat, npix, first, last);
        check("b0_npix", 32'(npix), 32'd16);
        check("b0_first", 32'(first), 32'hA000);
        check("b0_last", 32'(last), 32'hA00F);

        // Random traffic against the shadow model
        for (int it = 0; it < 40; it++) begin
            row  = 4'($urandom_range(0, 15));
            addr = 8'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    do_burst(row, lat, npix, first, last);
                    check("rnd_lat", 32'(lat), 32'd16);
                    check("rnd_npix", 32'(npix), 32'd16);
                    check("rnd_first", 32'(first), 32'(shadow[{row, 4'h0}]));
                    check("rnd_last", 32'(last), 32'(shadow[{row, 4'hF}]));
                end
                1: begin
                    host_op(1'b1, 1'b0, addr, 16'($urandom), 2'($urandom), waits);
                    check("rnd_wr_waits", 32'(waits), 32'd0);
                end
                2: begin
                    host_op(1'b0, 1'b1, addr, 16'h0, 2'b11, waits);
                    check("rnd_rd_waits", 32'(waits), 32'd0);
                    @(negedge clk);
                    check("rnd_rd_valid", 32'(avs_bus.avs_readdatavalid), 32'd1);
                end
                default: begin
                    fork
                        do_burst(row, lat, npix, first, last);
                        host_op(1'b0, 1'b1, addr, 16'h0, 2'b11, waits);
                    join
                    check("rnd_tie_waits", 32'(waits), 32'd18);
                    check("rnd_tie_npix", 32'(npix), 32'd16);
                end
            endcase
        end

        repeat (4) @(posedge clk);
        check("pix_queue_empty", 32'(pix_q.size()), 32'd0);
        check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
